// File: rtl/led_array_pkg.sv
// Shared definitions for the LED-array SPI master: frame geometry,
// FSM state encoding and a small constant helper.
package led_array_pkg;

    localparam int FRAME_BITS   = 32;
    localparam int CMD_W        = 8;
    localparam int DATA_W       = 24;
    localparam int CMD_FLAG_BIT = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD,
        ST_GAP
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_array_spi_timer.sv
// Loadable down-counter with terminal-count flag.
// Ports: clk, rst_n, load (load_val into count), tc (count is zero).
module led_array_spi_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A value of N-1 loaded on entry gives a state that lasts N cycles.
    assign tc = (cnt == '0);

endmodule

// File: rtl/led_array_spi_master.sv
// Mode-3 SPI master sending 32-bit {cmd,data} frames MSB first.
// Ports: i_CLK, i_RESET_n, i_START/i_CMD/i_DATA request, o_BUSY, o_DONE,
// o_SPI_CLK, o_SPI_ENA_n, o_SPI_DATA, o_SPI_DATA_OE (all registered).
module led_array_spi_master
    import led_array_pkg::*;
#(
    parameter int HALF_DIV = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP_CYC  = 4
) (
    input  logic              i_CLK,
    input  logic              i_RESET_n,
    input  logic              i_START,
    input  logic [CMD_W-1:0]  i_CMD,
    input  logic [DATA_W-1:0] i_DATA,
    output logic              o_BUSY,
    output logic              o_DONE,
    output logic              o_SPI_CLK,
    output logic              o_SPI_ENA_n,
    output logic              o_SPI_DATA,
    output logic              o_SPI_DATA_OE
);

    localparam int HW      = $clog2(HALF_DIV + 1);
    localparam int DLY_MAX = max3(CS_SETUP, CS_HOLD, GAP_CYC);
    localparam int DW      = $clog2(DLY_MAX + 1);

    localparam logic [HW-1:0] HALF_LD  = HW'(HALF_DIV - 1);
    localparam logic [DW-1:0] SETUP_LD = DW'(CS_SETUP - 1);
    localparam logic [DW-1:0] HOLD_LD  = DW'(CS_HOLD - 1);
    localparam logic [DW-1:0] GAP_LD   = DW'(GAP_CYC - 1);

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [4:0]              bit_q, bit_d;
    logic                    sck_q, sck_d;
    logic                    ena_n_q, ena_n_d;
    logic                    mosi_q, mosi_d;
    logic                    oe_q, oe_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    hp_load, hp_tc;
    logic                    dly_load, dly_tc;
    logic [DW-1:0]           dly_val;

    led_array_spi_timer #(.W(HW)) u_half (
        .clk      (i_CLK),
        .rst_n    (i_RESET_n),
        .load     (hp_load),
        .load_val (HALF_LD),
        .tc       (hp_tc)
    );

    led_array_spi_timer #(.W(DW)) u_dly (
        .clk      (i_CLK),
        .rst_n    (i_RESET_n),
        .load     (dly_load),
        .load_val (dly_val),
        .tc       (dly_tc)
    );

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b1;
            ena_n_q <= 1'b1;
            mosi_q  <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            ena_n_q <= ena_n_d;
            mosi_q  <= mosi_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        ena_n_d  = ena_n_q;
        mosi_d   = mosi_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hp_load  = 1'b0;
        dly_load = 1'b0;
        dly_val  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_START) begin
                    sr_d     = {i_CMD, i_DATA};
                    bit_d    = 5'(FRAME_BITS - 1);
                    busy_d   = 1'b1;
                    ena_n_d  = 1'b0;
                    oe_d     = 1'b1;
                    mosi_d   = i_CMD[CMD_FLAG_BIT];
                    dly_load = 1'b1;
                    dly_val  = SETUP_LD;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (dly_tc) begin
                    sck_d   = 1'b0;
                    hp_load = 1'b1;
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (hp_tc) begin
                    sck_d   = 1'b1;
                    hp_load = 1'b1;
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (hp_tc) begin
                    if (bit_q == '0) begin
                        dly_load = 1'b1;
                        dly_val  = HOLD_LD;
                        state_d  = ST_HOLD;
                    end else begin
                        // Next bit appears together with the falling edge.
                        sr_d    = sr_q << 1;
                        bit_d   = bit_q - 1'b1;
                        mosi_d  = sr_q[FRAME_BITS-2];
                        sck_d   = 1'b0;
                        hp_load = 1'b1;
                        state_d = ST_SHIFT_LO;
                    end
                end
            end
            ST_HOLD: begin
                if (dly_tc) begin
                    ena_n_d  = 1'b1;
                    oe_d     = 1'b0;
                    mosi_d   = 1'b0;
                    done_d   = 1'b1;
                    dly_load = 1'b1;
                    dly_val  = GAP_LD;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (dly_tc) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_BUSY        = busy_q;
    assign o_DONE        = done_q;
    assign o_SPI_CLK     = sck_q;
    assign o_SPI_ENA_n   = ena_n_q;
    assign o_SPI_DATA    = mosi_q;
    assign o_SPI_DATA_OE = oe_q;

endmodule

// File: tb/tb_led_array_spi_master.sv
// Scoreboard bench for led_array_spi_master: a slave model captures frames
// from two instances (HALF_DIV=2 and HALF_DIV=1) and compares to a queue.
module tb_led_array_spi_master;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int GAP_CYC  = 4;
    localparam int HD0      = 2;
    localparam int HD1      = 1;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        start [2];
    logic [7:0]  cmd   [2];
    logic [23:0] data  [2];
    logic        busy  [2];
    logic        done  [2];
    logic        sck   [2];
    logic        ena_n [2];
    logic        mosi  [2];
    logic        oe    [2];

    always #5 clk = ~clk;

    led_array_spi_master #(
        .HALF_DIV(HD0), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .GAP_CYC(GAP_CYC)
    ) dut0 (
        .i_CLK(clk), .i_RESET_n(rst_n[0]), .i_START(start[0]),
        .i_CMD(cmd[0]), .i_DATA(data[0]), .o_BUSY(busy[0]),
        .o_DONE(done[0]), .o_SPI_CLK(sck[0]), .o_SPI_ENA_n(ena_n[0]),
        .o_SPI_DATA(mosi[0]), .o_SPI_DATA_OE(oe[0])
    );

    led_array_spi_master #(
        .HALF_DIV(HD1), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .GAP_CYC(GAP_CYC)
    ) dut1 (
        .i_CLK(clk), .i_RESET_n(rst_n[1]), .i_START(start[1]),
        .i_CMD(cmd[1]), .i_DATA(data[1]), .o_BUSY(busy[1]),
        .o_DONE(done[1]), .o_SPI_CLK(sck[1]), .o_SPI_ENA_n(ena_n[1]),
        .o_SPI_DATA(mosi[1]), .o_SPI_DATA_OE(oe[1])
    );

    int vec = 0;
    int err = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          accepted [2];

    task automatic check(input string name, input logic ok,
                         input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (ok !== 1'b1) begin
            err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int exp_low(input int k);
        return CS_SETUP + 64 * ((k == 0) ? HD0 : HD1) + CS_HOLD;
    endfunction

    // Slave-side monitor and scoreboard
    logic        p_sck  [2];
    logic        p_ena  [2];
    logic        p_mosi [2];
    logic [31:0] shreg  [2];
    int          nbits  [2];
    int          nfall  [2];
    int          low_cnt[2];
    int          hi_cnt [2];
    int          since_done[2];
    bit          in_frame[2];
    int          done_cnt[2];
    bit          b2b[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            p_sck[k] = 1'b1; p_ena[k] = 1'b1; p_mosi[k] = 1'b0;
            shreg[k] = '0; nbits[k] = 0; nfall[k] = 0; low_cnt[k] = 0;
            hi_cnt[k] = -1; since_done[k] = -1; in_frame[k] = 0;
            done_cnt[k] = 0; b2b[k] = 0; accepted[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                check("reset_outputs",
                      sck[k] && ena_n[k] && !oe[k] && !busy[k]
                      && !done[k] && !mosi[k],
                      {26'd0, sck[k], ena_n[k], oe[k], busy[k],
                       done[k], mosi[k]},
                      32'b110000);
                in_frame[k] = 0;
                since_done[k] = -1;
                hi_cnt[k] = -1;
            end else begin
                logic fall_e, rise_e;
                logic [31:0] e;
                fall_e = p_ena[k] && !ena_n[k];
                rise_e = !p_ena[k] && ena_n[k];
                if (mosi[k] !== p_mosi[k])
                    check("mosi_timing",
                          (p_sck[k] && !sck[k]) || (ena_n[k] !== p_ena[k]),
                          {31'd0, mosi[k]}, {31'd0, p_mosi[k]});
                if (ena_n[k] && p_ena[k])
                    check("sck_idle_high", sck[k] === 1'b1,
                          {31'd0, sck[k]}, 32'd1);
                if (fall_e) begin
                    check("frame_start_oe_busy", oe[k] && busy[k],
                          {30'd0, oe[k], busy[k]}, 32'd3);
                    check("busy_fell_before_frame", since_done[k] < 0,
                          since_done[k], 32'hFFFF_FFFF);
                    if (b2b[k] && hi_cnt[k] > 0)
                        check("gap_ena_high", hi_cnt[k] == GAP_CYC + 1,
                              hi_cnt[k], GAP_CYC + 1);
                    hi_cnt[k] = -1;
                    since_done[k] = -1;
                    in_frame[k] = 1;
                    low_cnt[k] = 1;
                    nbits[k] = 0;
                    nfall[k] = 0;
                    shreg[k] = '0;
                end else if (!ena_n[k] && in_frame[k]) begin
                    low_cnt[k]++;
                    if (p_sck[k] && !sck[k]) nfall[k]++;
                    if (!p_sck[k] && sck[k]) begin
                        shreg[k] = {shreg[k][30:0], mosi[k]};
                        nbits[k]++;
                    end
                end
                if (rise_e && in_frame[k]) begin
                    in_frame[k] = 0;
                    check("done_with_ena_rise", done[k] === 1'b1,
                          {31'd0, done[k]}, 32'd1);
                    if (done[k]) done_cnt[k]++;
                    check("ena_low_cycles", low_cnt[k] == exp_low(k),
                          low_cnt[k], exp_low(k));
                    check("sck_edges", nbits[k] == 32 && nfall[k] == 32,
                          {nbits[k][15:0], nfall[k][15:0]},
                          {16'd32, 16'd32});
                    if (k == 0 && exp_q0.size() > 0) begin
                        e = exp_q0.pop_front();
                        check("frame0", shreg[k] == e, shreg[k], e);
                    end else if (k == 1 && exp_q1.size() > 0) begin
                        e = exp_q1.pop_front();
                        check("frame1", shreg[k] == e, shreg[k], e);
                    end else begin
                        check("unexpected_frame", 1'b0, shreg[k], 32'd0);
                    end
                    since_done[k] = 0;
                    hi_cnt[k] = b2b[k] ? 1 : -1;
                end else begin
                    check("no_stray_done", done[k] === 1'b0,
                          {31'd0, done[k]}, 32'd0);
                    if (ena_n[k] && hi_cnt[k] >= 0) hi_cnt[k]++;
                    if (since_done[k] >= 0) begin
                        since_done[k]++;
                        if (!busy[k]) begin
                            check("busy_fall_after_done",
                                  since_done[k] == GAP_CYC,
                                  since_done[k], GAP_CYC);
                            since_done[k] = -1;
                        end
                    end
                end
            end
            p_sck[k] = sck[k];
            p_ena[k] = ena_n[k];
            p_mosi[k] = mosi[k];
        end
    end

    // Stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_free(input int k);
        int n;
        n = 0;
        while (busy[k] && n < 3000) begin
            tick();
            n++;
        end
        if (busy[k]) check("busy_timeout", !busy[k], {31'd0, busy[k]}, 0);
    endtask

    task automatic push_exp(input int k, input logic [31:0] f);
        if (k == 0) exp_q0.push_back(f);
        else exp_q1.push_back(f);
        accepted[k]++;
    endtask

    task automatic send(input int k, input logic [7:0] c,
                        input logic [23:0] d);
        wait_free(k);
        cmd[k] = c;
        data[k] = d;
        start[k] = 1'b1;
        push_exp(k, {c, d});
        tick();
        start[k] = 1'b0;
        cmd[k] = 8'($urandom);
        data[k] = 24'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int n;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; start[k] = 1'b0;
            cmd[k] = '0; data[k] = '0;
        end
        repeat (5) tick();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        for (int i = 0; i < 10; i++) begin
            check("reset_idle",
                  {sck[0], ena_n[0], oe[0], busy[0], done[0]} == 5'b11000,
                  {27'd0, sck[0], ena_n[0], oe[0], busy[0], done[0]},
                  32'b11000);
            tick();
        end

        send(0, 8'h80, 24'h000100);
        wait_free(0);
        send(0, 8'h00, 24'h000100);
        wait_free(0);

        dc = done_cnt[0];
        send(0, 8'($urandom), 24'($urandom));
        repeat (39) tick();
        start[0] = 1'b1;
        data[0] = 24'hFFFFFF;
        tick();
        start[0] = 1'b0;
        wait_free(0);
        check("start_while_busy_one_done", done_cnt[0] == dc + 1,
              done_cnt[0], dc + 1);

        for (int i = 0; i < 6; i++) begin
            send(0, 8'($urandom), 24'($urandom));
            repeat ($urandom_range(1, 100)) tick();
            if (busy[0]) begin
                start[0] = 1'b1;
                tick();
                start[0] = 1'b0;
            end
        end
        wait_free(0);

        // Back-to-back frames with start held high
        b2b[1] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            n = 0;
            while (busy[1] && n < 3000) begin
                tick();
                n++;
            end
            if (busy[1])
                check("b2b_timeout", !busy[1], {31'd0, busy[1]}, 0);
            cmd[1] = 8'($urandom);
            data[1] = 24'($urandom);
            start[1] = 1'b1;
            push_exp(1, {cmd[1], data[1]});
            tick();
        end
        start[1] = 1'b0;
        wait_free(1);
        tick();
        b2b[1] = 1'b0;

        // Reset in the middle of a frame
        send(0, 8'($urandom), 24'($urandom));
        repeat (68) tick();
        @(posedge clk);
        #3;
        rst_n[0] = 1'b0;
        #1;
        check("async_reset_pins",
              ena_n[0] === 1'b1 && sck[0] === 1'b1 && done[0] === 1'b0,
              {29'd0, ena_n[0], sck[0], done[0]}, 32'b110);
        void'(exp_q0.pop_back());
        accepted[0]--;
        repeat (3) tick();
        rst_n[0] = 1'b1;
        repeat (3) tick();
        send(0, 8'h12, 24'h345678);
        wait_free(0);

        repeat (10) tick();
        check("queues_empty", exp_q0.size() == 0 && exp_q1.size() == 0,
              exp_q0.size() + exp_q1.size(), 0);
        check("done_count0", done_cnt[0] == accepted[0],
              done_cnt[0], accepted[0]);
        check("done_count1", done_cnt[1] == accepted[1],
              done_cnt[1], accepted[1]);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
